booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Parametrised, iterative radix-4 Booth multiplier.
- Retires one Booth digit per clock and supports signed and unsigned operands, selected per transaction.
- Valid/ready handshakes on both input and output, so it sits as a pipeline-stage compute unit between operand producers and result consumers.
- Successor to the combinational Booth encoder/partial-product datapath: generic width, sequential accumulation, backpressure.

Parameters:
- N, default 16: operand width; must be even and >= 4.
- W, default N+2: internal extended operand width (derived; not to be overridden).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- multiplicand  in  N  operand A.
- multiplier  in  N  operand B.
- is_signed  in  1  1 = two's-complement operands; 0 = unsigned. Sampled with the operands.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts product.
- product  out  2N  A*B, low 2N bits, exact in both modes.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, out_valid=0, product=0, accumulator=0, digit counter=0. in_ready=1 from the first cycle after reset.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, go to CALC.
  - CALC: one digit per cycle. After the last digit, go to DONE.
  - DONE: out_valid=1, product stable. On out_ready, go to IDLE.
- in_ready is combinational: (state==IDLE). No input is accepted in CALC or DONE.
- Capture on acceptance:
  - A and B are extended to W bits: sign-extended if is_signed, else zero-extended.
  - Accumulator is cleared; counter is set to 0.
- Digit i (i = 0 .. W/2-1 = N/2): triplet {B[2i+1], B[2i], B[2i-1]}, with B[-1] = 0.
  - Digit map: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
  - The partial product is sign-extended to 2N+4 bits, shifted left by 2i and added to the accumulator.
  - -A and -2A use inversion plus carry-in; the extension of +-2A is computed before the shift.
- Latency: N/2+1 CALC cycles. out_valid rises N/2+1 cycles after the accepting edge (N=16 gives 9).
- Throughput: one result per N/2+3 cycles minimum (accept, CALC cycles, DONE handshake).
- product = accumulator[2N-1:0], registered and updated at the edge leaving CALC. It holds while out_valid && !out_ready.
- Boundary conditions:
  - Most-negative x most-negative (signed) is exact.
  - Unsigned all-ones x all-ones is exact; zero extension adds the extra digit.
  - in_valid changes during CALC or DONE are ignored.
  - The out_ready and in_valid handshakes cannot occur in the same cycle; a new acceptance happens no earlier than the cycle after DONE exits.
- rst asserted in any state (including mid-CALC) aborts the operation at that edge. No out_valid is produced for the aborted operands.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- When defined: after digit i in CALC, if all extended-B bits above 2i+1 equal B[2i+1], remaining digits are zero. The FSM goes to DONE immediately, and latency drops to i+1 cycles. Results are identical.
- When undefined: latency is fixed at N/2+1 cycles.

Decomposition:
- Package booth_pkg holds:
  - State enum {IDLE, CALC, DONE}.
  - Digit-op typedef {ZERO, POS1, POS2, NEG1, NEG2}.
  - Width helper constants: digit count N/2+1, accumulator width 2N+4.
- Sub-module booth_radix4_digit: combinational triplet -> digit-op, plus the W+1-bit signed partial-product generator.
- The top level holds the FSM, counter, shift/add and handshake logic.

Test Plan (N=8 unless noted):
- Signed -7 x 3 (0xF9, 0x03): product=0xFFEB, out_valid exactly 5 cycles after acceptance, in_ready=0 throughout.
- Unsigned 255 x 255: product=0xFE01. Same operand bits with signed mode (-1 x -1): product=0x0001.
- Signed -128 x -128: product=0x4000. Signed -128 x 127: product=0xC080.
- Backpressure: hold out_ready=0 for 3 cycles in DONE. product and out_valid must stay stable and in_ready=0; after the handshake, in_ready=1 on the next cycle and back-to-back operands are accepted.
- rst pulsed on the 2nd CALC cycle: next cycle state=IDLE, out_valid=0, product=0. A following 5x5 (unsigned) returns 0x0019 normally.
- With BOOTH_EARLY_TERM_EN, signed 100 x 1: product=0x0064 with out_valid 1 cycle after acceptance. Random 10k-operand sweep (N=16, both modes) matches a reference model with and without the macro.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and width helpers for the radix-4 Booth multiplier.
//   state_e    : control FSM states
//   digit_op_e : decoded Booth digit operation
//   digit_count/acc_width : derived sizes for an N-bit operand
package booth_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_op_e;

  // Extended operand is N+2 bits, so there are (N+2)/2 = N/2+1 digits.
  function automatic int unsigned digit_count(input int unsigned n);
    return n / 2 + 1;
  endfunction

  // Room for the largest shifted partial product plus sign headroom.
  function automatic int unsigned acc_width(input int unsigned n);
    return 2 * n + 4;
  endfunction

endpackage

// File: rtl/booth_radix4_digit.sv
// Combinational radix-4 Booth digit: decodes a multiplier triplet and
// forms the (W+1)-bit signed partial product of the extended multiplicand.
// Negative digits are returned as the one's complement plus cin_c = 1.
//   triplet : {B[2i+1], B[2i], B[2i-1]}
//   a_ext   : multiplicand extended to W bits
//   pp_c    : partial product before the carry-in
//   cin_c   : carry-in completing the two's-complement negation
module booth_radix4_digit
  import booth_pkg::*;
#(
  parameter int unsigned W = 18
) (
  input  logic [2:0]   triplet,
  input  logic [W-1:0] a_ext,
  output logic [W:0]   pp_c,
  output logic         cin_c
);

  digit_op_e  op;
  logic [W:0] a1;
  logic [W:0] a2;

  // Triplet to digit decode.
  always_comb begin
    op = ZERO;
    unique case (triplet)
      3'b001, 3'b010: op = POS1;
      3'b011:         op = POS2;
      3'b100:         op = NEG2;
      3'b101, 3'b110: op = NEG1;
      default:        op = ZERO;
    endcase
  end

  // 2A is widened before any later shift so its sign bit is kept.
  assign a1 = {a_ext[W-1], a_ext};
  assign a2 = {a_ext, 1'b0};

  // Partial-product select.
  always_comb begin
    pp_c  = '0;
    cin_c = 1'b0;
    unique case (op)
      POS1: pp_c = a1;
      POS2: pp_c = a2;
      NEG1: begin pp_c = ~a1; cin_c = 1'b1; end
      NEG2: begin pp_c = ~a2; cin_c = 1'b1; end
      default: begin pp_c = '0; cin_c = 1'b0; end
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, with valid/ready
// handshakes on operands and product. Signed or unsigned per transaction.
// Optional macro BOOTH_EARLY_TERM_EN: finish as soon as the remaining
// multiplier digits are all zero (same results, shorter latency).
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake (in_ready = state is IDLE)
//   multiplicand, multiplier, is_signed : operands and mode
//   out_valid/out_ready   : product handshake
//   product               : low 2N bits of A*B
//   busy                  : state is not IDLE
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned W = N + 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int unsigned DIGITS = digit_count(N);
  localparam int unsigned ACC_W  = acc_width(N);
  localparam int unsigned CNT_W  = $clog2(DIGITS);
  localparam int unsigned LAST   = DIGITS - 1;
  localparam int unsigned PP_W   = W + 1;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W:0]         b_q, b_d;      // {B_ext, B[-1]}, shifted right 2 per digit
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]     product_q, product_d;
  logic               out_valid_q, out_valid_d;

  logic [PP_W-1:0]    pp;
  logic               cin;
  logic [CNT_W:0]     shamt;
  logic [ACC_W-1:0]   pp_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic               done_digit;

  booth_radix4_digit #(.W(W)) u_digit (
    .triplet (b_q[2:0]),
    .a_ext   (a_q),
    .pp_c    (pp),
    .cin_c   (cin)
  );

  // Sign-extend, weight by 4^i, and accumulate with the negation carry.
  always_comb begin
    shamt   = {cnt_q, 1'b0};
    pp_ext  = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
    acc_sum = acc_q + (pp_ext << shamt) + (ACC_W'(cin) << shamt);
  end

`ifdef BOOTH_EARLY_TERM_EN
  // Remaining triplets are all 000 or 111 when the unconsumed bits match.
  logic rest_uniform;
  assign rest_uniform = (b_q[W:2] == '0) || (&b_q[W:2]);
  assign done_digit   = (cnt_q == CNT_W'(LAST)) || rest_uniform;
`else
  assign done_digit   = (cnt_q == CNT_W'(LAST));
`endif

  // Next-state, datapath and handshake control.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = is_signed ? {{(W-N){multiplicand[N-1]}}, multiplicand}
                              : {{(W-N){1'b0}}, multiplicand};
          b_d     = is_signed ? {{(W-N){multiplier[N-1]}}, multiplier, 1'b0}
                              : {{(W-N){1'b0}}, multiplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        b_d   = {b_q[W], b_q[W], b_q[W:2]};
        cnt_d = cnt_q + CNT_W'(1);
        if (done_digit) begin
          product_d   = acc_sum[2*N-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at N=8 with hand-computed products.
module tb_booth_mult_seq;

  localparam int unsigned N = 8;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  booth_mult_seq #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .is_signed    (is_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected cycles from acceptance to out_valid.
  function automatic int exp_lat(input logic [7:0] b, input logic s);
    logic [9:0] bx;
    bx = s ? {{2{b[7]}}, b} : {2'b00, b};
    for (int i = 0; i <= 4; i++) begin
      logic ok;
      ok = 1'b1;
      for (int k = 2 * i + 2; k < 10; k++)
        if (bx[k] != bx[2*i+1]) ok = 1'b0;
      if (EARLY && ok) return i + 1;
    end
    return 5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; garbage on the inputs while busy must be ignored.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp, input int hold);
    int cyc;
    logic [15:0] held;
    chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; multiplicand = a; multiplier = b; is_signed = s;
    step();
    multiplicand = ~a; multiplier = ~b; is_signed = ~s;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, ".timeout"}, 32'(out_valid), 32'd1);
    chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat(b, s)));
    chk({tag, ".product"}, 32'(product), 32'(exp));
    held = product;
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, ".hold_prod"}, 32'(product), 32'(exp));
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_post"}, 32'(in_ready), 32'd1);
    chk({tag, ".prod_kept"}, 32'(product), 32'(held));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    multiplicand = '0; multiplier = '0; is_signed = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.product", 32'(product), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);

    run_op("s_m7x3",     8'hF9, 8'h03, 1'b1, 16'hFFEB, 0);
    run_op("u_255x255",  8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    run_op("s_m1xm1",    8'hFF, 8'hFF, 1'b1, 16'h0001, 0);
    run_op("s_m128sq",   8'h80, 8'h80, 1'b1, 16'h4000, 0);
    run_op("s_m128x127", 8'h80, 8'h7F, 1'b1, 16'hC080, 0);
    run_op("s_100x1",    8'h64, 8'h01, 1'b1, 16'h0064, 0);
    run_op("u_128x2",    8'h80, 8'h02, 1'b0, 16'h0100, 0);
    run_op("s_m128x2",   8'h80, 8'h02, 1'b1, 16'hFF00, 0);
    run_op("bp_18x52",   8'h12, 8'h34, 1'b0, 16'h03A8, 3);
    run_op("b2b_3x7",    8'h03, 8'h07, 1'b0, 16'h0015, 0);

    // Abort on the second CALC cycle.
    in_valid = 1'b1; multiplicand = 8'h07; multiplier = 8'h55; is_signed = 1'b0;
    step();
    in_valid = 1'b0;
    chk("abort.busy1", 32'(busy), 32'd1);
    step();
    chk("abort.busy2", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.product", 32'(product), 32'd0);
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort.no_valid", 32'(out_valid), 32'd0);
    end
    run_op("u_5x5", 8'h05, 8'h05, 1'b0, 16'h0019, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
